instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that sits directly upstream of `opcode_decoder`. It holds the program counter, fetches 32-bit instruction words from instruction memory with a request/valid handshake, and presents the current instruction and its opcode field to the decoder. It resolves JUMP and BRA control flow, stalls on back-pressure, recovers from memory timeouts and stops permanently on HALT. It drives NOP whenever no instruction is valid, so the decoder never asserts a spurious write enable.

## Interface
- `PC_WIDTH`, 8, word-address width of the PC and `imem_addr`.
- `RESET_PC`, 0, PC value loaded on reset.
- `TIMEOUT`, 15, number of WAIT cycles without `imem_valid` before the fetch is re-issued (range 1..255).
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- `imem_req`  out  1  fetch request, high for exactly one cycle per fetch.
- `imem_addr`  out  PC_WIDTH  word address, equal to the PC.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_valid`=1 in WAIT.
- `imem_valid`  in  1  memory response strobe.
- `stall`  in  1  downstream hold; keeps the current instruction issued.
- `branch_cond`  in  1  BRA condition; sampled on the edge that leaves ISSUE.
- `instr`  out  32  captured instruction word.
- `instr_valid`  out  1  high while in ISSUE.
- `opcode`  out  6  `instr[31:26]` when `instr_valid`=1, else 6'b000000 (NOP).
- `pc_out`  out  PC_WIDTH  address of the instruction held in `instr`.
- `halted`  out  1  high in HALT.
- `fetch_err`  out  1  sticky flag; set on any timeout, cleared only by reset.

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, HALT. Reset enters IDLE.
- Reset values: state=IDLE, pc=`RESET_PC`, instr=0, pc_out=`RESET_PC`, timeout counter=0, fetch_err=0. Because every output is decoded from these registers, the outputs at reset are: imem_req=0, instr_valid=0, opcode=0, halted=0.
- Output decode: imem_req=(state==FETCH); imem_addr=pc; instr_valid=(state==ISSUE); halted=(state==HALT).
- IDLE -> FETCH unconditionally on the first edge after reset deasserts.
- FETCH -> WAIT after one cycle. The timeout counter clears on entry to WAIT. `imem_valid` seen during FETCH is ignored.
- WAIT:
  - If `imem_valid`=1: capture instr<=imem_rdata and pc_out<=pc, then go to ISSUE.
  - Else if the counter equals TIMEOUT-1: set fetch_err and go to FETCH with the same pc (re-issue).
  - Else increment the counter.
  - When `imem_valid` arrives on the timeout cycle, valid wins and fetch_err is not set.
- ISSUE:
  - If stall=1, hold. instr, opcode and pc_out stay stable and instr_valid stays 1.
  - If stall=0, update pc and go to FETCH, or to HALT when opcode==6'b111111.
- Next-PC rules, all results truncated to PC_WIDTH (wrap-around):
  - JUMP (6'b010101): pc <= instr[PC_WIDTH-1:0].
  - BRA (6'b010110) with branch_cond=1: pc <= pc + 1 + sign_extend(instr[15:0]).
  - BRA with branch_cond=0, and every other opcode: pc <= pc + 1.
- HALT is terminal. No requests are made and opcode=0 until reset.
- Reset mid-operation (any state) aborts immediately. A late `imem_valid` after reset is ignored because the block is not in WAIT.

## Timing
- Minimum issue period is 3 cycles (FETCH, WAIT with `imem_valid`, ISSUE). Each stall cycle and each extra WAIT cycle adds 1.
- Fetch latency: `imem_valid` in WAIT cycle n gives instr_valid=1 in cycle n+1.
- Request to reissue: a timeout re-raises imem_req TIMEOUT+1 cycles after the original request cycle.
- pc wrap: with PC_WIDTH=8, pc=8'hFF increments to 8'h00; BRA offset -1 from pc=0 targets pc=0.
- opcode changes only on edges entering or leaving ISSUE, so the decoder sees stable input for the whole ISSUE period.

## Test plan
- Sequential fetch: memory answers 1 cycle after request with ADD words at 0,1,2 -> imem_addr 0,1,2 on requests, pc_out 0,1,2, instr_valid once every 3 cycles, opcode 6'b000001 only while instr_valid.
- Control flow: JUMP with target 8'h40 at pc 5 -> next request at address 8'h40. BRA at 8'h40 with imm 16'hFFFE and branch_cond=1 -> next request at 8'h3F. With branch_cond=0 -> next request at 8'h41.
- Stall: hold stall=1 for 4 cycles during ISSUE -> instr_valid, opcode and pc_out stable for 5 cycles, and no imem_req until the cycle after stall drops.
- Timeout: no `imem_valid` for 15 WAIT cycles -> fetch_err=1 and imem_req re-asserted with the same address. Then answer -> normal issue, and fetch_err stays 1.
- HALT and wrap: start with RESET_PC=8'hFF -> second fetch at 8'h00. Then an instruction with opcode 6'b111111 -> halted=1, no further imem_req, opcode=0.
- Async reset asserted in WAIT, then `imem_valid` pulsed during reset -> all outputs at reset values immediately, and the first request after release is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage feeding opcode_decoder. Holds the PC, fetches
//   32-bit words over a one-cycle request / valid-strobe handshake, resolves
//   JUMP and BRA, holds on downstream stall, re-issues a fetch after TIMEOUT
//   silent WAIT cycles and stops for good on HALT.
//
// Ports
//   clock, reset      clock and asynchronous active-high reset
//   imem_req          one-cycle fetch request (high in FETCH)
//   imem_addr         word address of the fetch (the PC)
//   imem_rdata        instruction word, sampled with imem_valid in WAIT
//   imem_valid        memory response strobe
//   stall             downstream hold while an instruction is issued
//   branch_cond       BRA condition, sampled when leaving ISSUE
//   instr             captured instruction word
//   instr_valid       high while an instruction is issued
//   opcode            instr[31:26] while issued, NOP (0) otherwise
//   pc_out            address of the word held in instr
//   halted            high once HALT has been executed
//   fetch_err         sticky memory-timeout flag, cleared only by reset
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         TIMEOUT  = 15
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                branch_cond,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [5:0]          opcode,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                halted,
  output logic                fetch_err
);

  localparam logic [5:0] OP_JUMP  = 6'b010101;
  localparam logic [5:0] OP_BRA   = 6'b010110;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t              state, state_d;
  logic [PC_WIDTH-1:0] pc, pc_d, pc_out_d;
  logic [PC_WIDTH-1:0] pc_seq, pc_bra;
  logic [31:0]         instr_d, imm_sext;
  logic [7:0]          cnt, cnt_d;
  logic                err_d;

  // Branch target computed at 32 bits and truncated, so negative offsets
  // wrap naturally within the PC width.
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign pc_seq   = pc + PC_WIDTH'(1);
  assign pc_bra   = PC_WIDTH'(32'(pc_seq) + imm_sext);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      pc_out    <= RESET_PC;
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      instr     <= instr_d;
      pc_out    <= pc_out_d;
      cnt       <= cnt_d;
      fetch_err <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    instr_d  = instr;
    pc_out_d = pc_out;
    cnt_d    = cnt;
    err_d    = fetch_err;
    case (state)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A response on the timeout cycle still counts as a hit.
        if (imem_valid) begin
          instr_d  = imem_rdata;
          pc_out_d = pc;
          state_d  = S_ISSUE;
        end else if (cnt == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          case (instr[31:26])
            OP_JUMP: pc_d = instr[PC_WIDTH-1:0];
            OP_BRA:  pc_d = branch_cond ? pc_bra : pc_seq;
            default: pc_d = pc_seq;
          endcase
          state_d = (instr[31:26] == OP_HALT) ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign opcode      = instr_valid ? instr[31:26] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int unsigned PW  = 8;
  localparam logic [7:0]  RPC = 8'hFF;
  localparam int          TO  = 15;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_JUMP = 6'b010101;
  localparam logic [5:0] OP_BRA  = 6'b010110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        branch_cond = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [7:0]  pc_out;
  logic        halted;
  logic        fetch_err;

  always #5 clock = ~clock;

  instr_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .branch_cond(branch_cond),
    .instr(instr), .instr_valid(instr_valid), .opcode(opcode),
    .pc_out(pc_out), .halted(halted), .fetch_err(fetch_err)
  );

  int tests = 0;
  int fails = 0;

  // Transaction-level model: next fetch address, address of the issued
  // word, sticky error, halt, plus the per-cycle expected handshake outputs.
  logic [7:0] mpc, m_pcout;
  logic       m_err, m_halted;
  logic       exp_req, exp_valid;
  logic [5:0] exp_op;
  bit         chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("imem_req",    32'(imem_req),    32'(exp_req));
      check("instr_valid", 32'(instr_valid), 32'(exp_valid));
      check("opcode",      32'(opcode),      32'(exp_op));
      check("pc_out",      32'(pc_out),      32'(m_pcout));
      check("halted",      32'(halted),      32'(m_halted));
      check("fetch_err",   32'(fetch_err),   32'(m_err));
      if (!m_halted) check("imem_addr", 32'(imem_addr), 32'(mpc));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_exp(input logic req, input logic vld, input logic [5:0] op);
    exp_req   = req;
    exp_valid = vld;
    exp_op    = op;
  endtask

  // One complete fetch: request, `delay` WAIT cycles (beyond TO means no
  // answer -> timeout and re-issue), then stalls+1 ISSUE cycles.
  task automatic do_fetch(input logic [31:0] word, input int delay,
                          input int stalls, input logic cond);
    bit          done  = 0;
    bit          retry = 0;
    int          d     = delay;
    int          tgt;
    logic [31:0] r;
    while (!done) begin
      tick();
      if (retry) m_err = 1'b1;
      set_exp(1'b1, 1'b0, 6'd0);
      imem_valid  = 1'($urandom_range(0, 1));
      r           = $urandom;
      imem_rdata  = r;
      stall       = 1'($urandom_range(0, 1));
      branch_cond = 1'($urandom_range(0, 1));
      for (int k = 1; k <= TO; k++) begin
        tick();
        set_exp(1'b0, 1'b0, 6'd0);
        stall       = 1'($urandom_range(0, 1));
        branch_cond = 1'($urandom_range(0, 1));
        if (k == d) begin
          imem_valid = 1'b1;
          imem_rdata = word;
          done       = 1;
          break;
        end
        imem_valid = 1'b0;
        r          = $urandom;
        imem_rdata = r;
      end
      if (!done) begin
        retry = 1;
        d     = $urandom_range(1, 3);
      end
    end
    for (int s = 0; s <= stalls; s++) begin
      tick();
      if (s == 0) m_pcout = mpc;
      set_exp(1'b0, 1'b1, word[31:26]);
      imem_valid  = 1'($urandom_range(0, 1));
      r           = $urandom;
      imem_rdata  = r;
      stall       = (s < stalls);
      branch_cond = (s < stalls) ? 1'($urandom_range(0, 1)) : cond;
    end
    // Advance the model only after the last ISSUE cycle has been compared.
    @(negedge clock);
    #1;
    case (word[31:26])
      OP_JUMP: mpc = word[7:0];
      OP_BRA: begin
        if (cond) begin
          tgt = int'(mpc) + 1 + int'($signed(word[15:0]));
          mpc = 8'(tgt);
        end else begin
          mpc = mpc + 8'd1;
        end
      end
      default: mpc = mpc + 8'd1;
    endcase
    if (word[31:26] == OP_HALT) m_halted = 1'b1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] low);
    return {op, low};
  endfunction

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    int          dly;
    mpc = RPC; m_pcout = RPC; m_err = 1'b0; m_halted = 1'b0;
    set_exp(1'b0, 1'b0, 6'd0);
    chk_en = 1;

    repeat (2) tick();
    tick();
    reset = 1'b0;                       // IDLE cycle

    // Wrap from RESET_PC and sequential ADD fetches
    do_fetch(mk(OP_ADD, 26'h0000011), 1, 0, 1'b0);
    check("model_wrap", 32'(mpc), 32'h00);
    do_fetch(mk(OP_ADD, 26'h0000022), 1, 0, 1'b0);
    do_fetch(mk(OP_ADD, 26'h0000033), 1, 0, 1'b0);
    do_fetch(mk(OP_ADD, 26'h0000044), 1, 0, 1'b0);
    do_fetch(mk(OP_ADD, 26'h0000055), 2, 0, 1'b0);
    do_fetch(mk(OP_ADD, 26'h0000066), 3, 0, 1'b0);
    check("model_seq", 32'(mpc), 32'h05);

    // Control flow
    do_fetch(mk(OP_JUMP, 26'h0000040), 1, 0, 1'b0);
    check("model_jump", 32'(mpc), 32'h40);
    do_fetch(mk(OP_BRA, 26'h000FFFE), 1, 0, 1'b1);
    check("model_bra_taken", 32'(mpc), 32'h3F);
    do_fetch(mk(OP_JUMP, 26'h0000040), 1, 0, 1'b0);
    do_fetch(mk(OP_BRA, 26'h000FFFE), 1, 0, 1'b0);
    check("model_bra_not", 32'(mpc), 32'h41);

    // Stall, timeout, valid on the timeout cycle
    do_fetch(mk(OP_ADD, 26'h0000077), 1, 4, 1'b0);
    do_fetch(mk(OP_ADD, 26'h0000088), TO + 1, 0, 1'b0);
    check("model_err", 32'(m_err), 32'h1);
    do_fetch(mk(OP_ADD, 26'h0000099), TO, 0, 1'b0);

    // BRA -1 at pc 0 targets pc 0
    do_fetch(mk(OP_JUMP, 26'h0000000), 1, 0, 1'b0);
    do_fetch(mk(OP_BRA, 26'h000FFFF), 1, 0, 1'b1);
    check("model_bra_self", 32'(mpc), 32'h00);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1:    op = OP_JUMP;
        2, 3:    op = OP_BRA;
        default: begin
          op = 6'($urandom_range(0, 62));
        end
      endcase
      dly = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(1, 4));
      do_fetch({op, r[25:0]}, dly, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in WAIT with a response pulsed during reset
    tick(); set_exp(1'b1, 1'b0, 6'd0); imem_valid = 1'b0;
    tick(); set_exp(1'b0, 1'b0, 6'd0);
    tick();
    @(negedge clock);
    #2;
    reset = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hFC00_0000;
    mpc = RPC; m_pcout = RPC; m_err = 1'b0; m_halted = 1'b0;
    set_exp(1'b0, 1'b0, 6'd0);
    #1;
    check("async_req",   32'(imem_req),    32'h0);
    check("async_valid", 32'(instr_valid), 32'h0);
    check("async_op",    32'(opcode),      32'h0);
    check("async_err",   32'(fetch_err),   32'h0);
    check("async_pcout", 32'(pc_out),      32'(RPC));
    check("async_addr",  32'(imem_addr),   32'(RPC));
    tick(); imem_valid = 1'b1;
    tick(); imem_valid = 1'b0;
    tick(); reset = 1'b0; imem_valid = 1'b1;   // IDLE, late strobe ignored

    // Restart at RESET_PC, then HALT
    do_fetch(mk(OP_ADD, 26'h00000AA), 1, 0, 1'b0);
    check("model_wrap2", 32'(mpc), 32'h00);
    do_fetch(mk(OP_HALT, 26'h0000000), 1, 1, 1'b0);
    repeat (8) begin
      tick();
      set_exp(1'b0, 1'b0, 6'd0);
      imem_valid = 1'($urandom_range(0, 1));
      stall      = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
